// File: rtl/nibble_prog_loader.sv
// Nibble-serial program loader: takes length/data/checksum over valid/ready and writes the program RAM.
// Optional watchdog enabled by defining NIBBLE_LOADER_TIMEOUT_EN (parameter TIMEOUT_CYC).
module nibble_prog_loader #(
   parameter int                 ADDR_W     = 12,
   parameter logic [ADDR_W-1:0]  START_ADDR = '0
`ifdef NIBBLE_LOADER_TIMEOUT_EN
   ,parameter int                TIMEOUT_CYC = 1024
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_req,
   input  logic              in_valid,
   input  logic [3:0]        in_nibble,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_LEN0 = 4'd1;
   localparam logic [3:0] S_LEN1 = 4'd2;
   localparam logic [3:0] S_LEN2 = 4'd3;
   localparam logic [3:0] S_DHI  = 4'd4;
   localparam logic [3:0] S_DLO  = 4'd5;
   localparam logic [3:0] S_CS0  = 4'd6;
   localparam logic [3:0] S_CS1  = 4'd7;
   localparam logic [3:0] S_DONE = 4'd8;
   localparam logic [3:0] S_ERR  = 4'd9;

   logic [3:0]        state_q, state_d;
   logic [11:0]       len_q, len_d;
   logic [11:0]       cnt_q, cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        hi_q, hi_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              active, accept, restart, timeout;
   logic [11:0]       len_new, cnt_inc;
   logic [7:0]        byte_new;

   assign active   = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
   assign accept   = active && in_valid;
   assign restart  = !active && load_req;
   assign len_new  = {len_q[7:0], in_nibble};
   assign cnt_inc  = cnt_q + 12'd1;
   assign byte_new = {hi_q, in_nibble};

`ifdef NIBBLE_LOADER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q;

   // Counts busy cycles since the last accepted nibble; trips when it hits TIMEOUT_CYC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                       wd_q <= '0;
      else if (!active || accept)       wd_q <= '0;
      else if (!timeout)                wd_q <= wd_q + 1'b1;
   end
   assign timeout = active && !accept && (wd_q == WD_W'(TIMEOUT_CYC));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      csum_d  = csum_q;
      addr_d  = addr_q;
      hi_d    = hi_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (restart) begin
         state_d = S_LEN0;
         len_d   = '0;
         cnt_d   = '0;
         csum_d  = '0;
         addr_d  = START_ADDR;
      end else if (timeout) begin
         state_d = S_ERR;
      end else if (accept) begin
         case (state_q)
            S_LEN0: begin len_d = len_new; state_d = S_LEN1; end
            S_LEN1: begin len_d = len_new; state_d = S_LEN2; end
            S_LEN2: begin
               len_d   = len_new;
               state_d = (len_new == 12'd0) ? S_CS0 : S_DHI;
            end
            S_DHI: begin hi_d = in_nibble; state_d = S_DLO; end
            S_DLO: begin
               // RAM write is issued one cycle after the low nibble lands
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = byte_new;
               addr_d  = addr_q + 1'b1;
               csum_d  = csum_q + byte_new;
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == len_q) ? S_CS0 : S_DHI;
            end
            S_CS0: begin hi_d = in_nibble; state_d = S_CS1; end
            S_CS1: state_d = (byte_new == csum_q) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
         addr_q  <= '0;
         hi_q    <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         addr_q  <= addr_d;
         hi_q    <= hi_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign in_ready  = active;
   assign busy      = active;
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   // A failed image keeps the uP in reset
   assign cpu_hold  = active || (state_q == S_ERR);
   assign mem_we    = we_q;
   assign mem_addr  = waddr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_nibble_prog_loader.sv
// Scoreboard bench for nibble_prog_loader: instance A at address 0, instance B at 0xFFE for wrap.
module tb_nibble_prog_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_req_a = 1'b0, load_req_b = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_nibble = 4'h0;
   logic        rdy_a, we_a, hold_a, busy_a, done_a, err_a;
   logic        rdy_b, we_b, hold_b, busy_b, done_b, err_b;
   logic [11:0] addr_a, addr_b;
   logic [7:0]  wd_a, wd_b;

   int checks = 0;
   int errors = 0;
   logic [19:0] exp_a[$];
   logic [19:0] exp_b[$];
   logic [7:0]  bytes[$];

   always #5 clk = ~clk;

`ifdef NIBBLE_LOADER_TIMEOUT_EN
   nibble_prog_loader #(.ADDR_W(12), .START_ADDR(12'h000), .TIMEOUT_CYC(16)) u_a (
      .clk(clk), .reset(reset), .load_req(load_req_a), .in_valid(in_valid), .in_nibble(in_nibble),
      .in_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
      .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .err(err_a));
   nibble_prog_loader #(.ADDR_W(12), .START_ADDR(12'hFFE), .TIMEOUT_CYC(16)) u_b (
      .clk(clk), .reset(reset), .load_req(load_req_b), .in_valid(in_valid), .in_nibble(in_nibble),
      .in_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
      .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .err(err_b));
`else
   nibble_prog_loader #(.ADDR_W(12), .START_ADDR(12'h000)) u_a (
      .clk(clk), .reset(reset), .load_req(load_req_a), .in_valid(in_valid), .in_nibble(in_nibble),
      .in_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
      .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .err(err_a));
   nibble_prog_loader #(.ADDR_W(12), .START_ADDR(12'hFFE)) u_b (
      .clk(clk), .reset(reset), .load_req(load_req_b), .in_valid(in_valid), .in_nibble(in_nibble),
      .in_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
      .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .err(err_b));
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitors: every mem_we must match the oldest expected {addr,data}
   always @(negedge clk) begin
      if (we_a) begin
         checks++;
         if (exp_a.size() == 0) begin
            errors++;
            $display("FAIL write_a: unexpected write %03h=%02h", addr_a, wd_a);
         end else begin
            logic [19:0] e;
            e = exp_a.pop_front();
            if ({addr_a, wd_a} !== e) begin
               errors++;
               $display("FAIL write_a: got %03h=%02h expected %03h=%02h", addr_a, wd_a, e[19:8], e[7:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (we_b) begin
         checks++;
         if (exp_b.size() == 0) begin
            errors++;
            $display("FAIL write_b: unexpected write %03h=%02h", addr_b, wd_b);
         end else begin
            logic [19:0] e;
            e = exp_b.pop_front();
            if ({addr_b, wd_b} !== e) begin
               errors++;
               $display("FAIL write_b: got %03h=%02h expected %03h=%02h", addr_b, wd_b, e[19:8], e[7:0]);
            end
         end
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_req(input bit sel);
      if (sel) load_req_b = 1'b1; else load_req_a = 1'b1;
      @(posedge clk); #1;
      load_req_a = 1'b0;
      load_req_b = 1'b0;
   endtask

   task automatic send_nib(input bit sel, input logic [3:0] n, input int gap);
      bit ok;
      if (gap > 0) idle(gap);
      in_valid  = 1'b1;
      in_nibble = n;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (sel ? rdy_b : rdy_a) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      if (!ok) begin
         errors++;
         $display("FAIL handshake: in_ready never seen for nibble %0h", n);
      end
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b, input logic [11:0] a, input int gap);
      if (sel) exp_b.push_back({a, b}); else exp_a.push_back({a, b});
      send_nib(sel, b[7:4], gap);
      send_nib(sel, b[3:0], gap ? ($urandom_range(0, 2)) : 0);
   endtask

   // Full load of the bytes queue; gapped when rand_gap is set
   task automatic do_load(input bit sel, input logic [11:0] start, input logic [7:0] cs, input bit rand_gap);
      logic [11:0] n;
      n = 12'(bytes.size());
      pulse_req(sel);
      send_nib(sel, n[11:8], 0);
      send_nib(sel, n[7:4], 0);
      send_nib(sel, n[3:0], 0);
      for (int i = 0; i < bytes.size(); i++)
         send_byte(sel, bytes[i], start + 12'(i), rand_gap ? int'($urandom_range(0, 3)) : 0);
      send_nib(sel, cs[7:4], 0);
      send_nib(sel, cs[3:0], 0);
   endtask

   task automatic check_end(input string name, input bit sel, input bit e_done, input bit e_err, input bit e_hold);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({name, "_pending"}, sel ? exp_b.size() : exp_a.size(), 0);
      chk({name, "_done"}, sel ? done_b : done_a, e_done);
      chk({name, "_err"},  sel ? err_b  : err_a,  e_err);
      chk({name, "_hold"}, sel ? hold_b : hold_a, e_hold);
      chk({name, "_busy"}, sel ? busy_b : busy_a, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2;
      chk("rst_outs_a", {rdy_a, we_a, hold_a, busy_a, done_a, err_a}, 6'b0);
      chk("rst_addr_a", {addr_a, wd_a}, 20'h0);
      #20;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready", rdy_a, 1'b0);

      // basic load: 0xA5@0, 0x3C@1, checksum 0xE1
      bytes = '{8'hA5, 8'h3C};
      do_load(0, 12'h000, 8'hE1, 0);
      check_end("basic", 0, 1, 0, 0);

      // bad checksum
      do_load(0, 12'h000, 8'h00, 0);
      check_end("badcs", 0, 0, 1, 1);

      // restart from ERR, gapped 16-byte load 0x10..0x1F, sum 0x178 -> 0x78
      bytes = {};
      for (int i = 0; i < 16; i++) bytes.push_back(8'h10 + 8'(i));
      do_load(0, 12'h000, 8'h78, 1);
      check_end("gap16", 0, 1, 0, 0);

      // zero length
      bytes = {};
      do_load(0, 12'h000, 8'h00, 0);
      check_end("zero", 0, 1, 0, 0);

      // address wrap on instance B: 1,2,3 at FFE,FFF,000; sum 0x06
      bytes = '{8'h01, 8'h02, 8'h03};
      do_load(1, 12'hFFE, 8'h06, 0);
      check_end("wrap", 1, 1, 0, 0);

      // load_req mid-load ignored: 0x5A,0x5A sum 0xB4 at 0,1
      pulse_req(0);
      send_nib(0, 4'h0, 0); send_nib(0, 4'h0, 0); send_nib(0, 4'h2, 0);
      send_byte(0, 8'h5A, 12'h000, 0);
      pulse_req(0);
      chk("midreq_busy", busy_a, 1'b1);
      send_byte(0, 8'h5A, 12'h001, 0);
      send_nib(0, 4'hB, 0); send_nib(0, 4'h4, 0);
      check_end("midreq", 0, 1, 0, 0);

      // async reset after the first data byte of a 4-byte load
      pulse_req(0);
      send_nib(0, 4'h0, 0); send_nib(0, 4'h0, 0); send_nib(0, 4'h4, 0);
      send_byte(0, 8'h11, 12'h000, 0);
      @(posedge clk); #3;
      chk("pre_rst_busy", busy_a, 1'b1);
      reset = 1'b0;
      #1;
      chk("arst_outs", {rdy_a, we_a, hold_a, busy_a, done_a, err_a}, 6'b0);
      chk("arst_addr", {addr_a, wd_a}, 20'h0);
      chk("arst_pending", exp_a.size(), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", rdy_a, 1'b0);

`ifdef NIBBLE_LOADER_TIMEOUT_EN
      // stall in DATA_LO: only the high nibble of the first byte is sent
      pulse_req(0);
      send_nib(0, 4'h0, 0); send_nib(0, 4'h0, 0); send_nib(0, 4'h1, 0);
      send_nib(0, 4'h7, 0);
      idle(10);
      chk("to_not_yet", err_a, 1'b0);
      idle(12);
      chk("to_err", err_a, 1'b1);
      chk("to_hold", hold_a, 1'b1);
      chk("to_busy", busy_a, 1'b0);
      chk("to_pending", exp_a.size(), 0);
`endif

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
